buffer_sequencer: RTL and testbench
===================================

BUFFER_SEQUENCER -- requirements
Module: buffer_sequencer

Interface
REQ-001 SHALL have parameter N_BUF, 8, number of memory buffers sequenced.
REQ-002 SHALL have parameter ADDR_RAM, 10, buffer address width.
REQ-003 SHALL have parameter WID_PE_BITS, 16, data word width.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a load+stream job.
REQ-007 SHALL have port abort  input  1  synchronous job cancel.
REQ-008 SHALL have port cfg_words  input  ADDR_RAM+1  words per buffer, valid range 1..2^ADDR_RAM.
REQ-009 SHALL have port cfg_nbuf  input  $clog2(N_BUF)+1  buffers used, valid range 1..N_BUF.
REQ-010 SHALL have ports in_valid / in_ready / in_data  input / output / input  1 / 1 / WID_PE_BITS  serial load stream.
REQ-011 SHALL have port pe_stall  input  1  consumer stall; blocks read issue that cycle.
REQ-012 SHALL have port buf_mode  output  1  0 = serial (load), 1 = parallel (stream).
REQ-013 SHALL have ports buf_w_en / buf_w_addr / buf_w_data  output  N_BUF / ADDR_RAM / WID_PE_BITS  buffer write, one-hot enable.
REQ-014 SHALL have ports buf_r_en / buf_r_addr  output  N_BUF / ADDR_RAM  parallel read enables and shared read address.
REQ-015 SHALL have ports rd_valid / rd_last  output  1 / 1  buffer read data valid / final row.
REQ-016 SHALL have ports busy / done / err  output  1 / 1 / 1  status; done and err are one-cycle pulses.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, STREAM, DONE.
REQ-018 IDLE: start with valid cfg SHALL register cfg_words and cfg_nbuf and go to LOAD; word and buffer counters cleared.
REQ-019 IDLE: start with cfg_words==0, cfg_nbuf==0 or cfg_nbuf>N_BUF SHALL pulse err the next cycle and remain IDLE.
REQ-020 start outside IDLE SHALL be ignored, with no effect on counters or cfg.
REQ-021 in_ready SHALL be 1 only in LOAD; a word is accepted when in_valid & in_ready.
REQ-022 On acceptance, the same cycle SHALL assert buf_w_en = one-hot(buf_cnt), buf_w_addr = word_cnt, buf_w_data = in_data (combinational); otherwise buf_w_en = 0.
REQ-023 Fill order SHALL be buffer-major: word_cnt 0..cfg_words-1 wraps to 0 with buf_cnt+1.
REQ-024 Acceptance of word (cfg_nbuf-1, cfg_words-1) SHALL move the FSM to STREAM next cycle.
REQ-025 buf_mode SHALL be 0 in IDLE/LOAD/DONE and 1 in STREAM.
REQ-026 STREAM: each cycle with pe_stall=0 SHALL issue a read: buf_r_en = low cfg_nbuf bits set, buf_r_addr = rd_cnt, rd_cnt+1; with pe_stall=1, buf_r_en = 0 and rd_cnt holds.
REQ-027 rd_valid SHALL be registered, high exactly one cycle after each issued read; rd_last is high with the rd_valid of address cfg_words-1.
REQ-028 Issuing the read of address cfg_words-1 SHALL move to DONE; DONE lasts one cycle with done=1, rd_valid=1, rd_last=1, then IDLE.
REQ-029 busy SHALL be 1 in LOAD, STREAM and DONE.
REQ-030 abort SHALL force IDLE next cycle from any state; in the abort cycle in_ready=0, buf_w_en=0, buf_r_en=0; no done pulse; an in-flight rd_valid is suppressed.
REQ-031 abort and start in the same IDLE cycle: abort SHALL win and the job SHALL NOT start.
REQ-032 Counters SHALL be sized so that cfg_words = 2^ADDR_RAM runs without overflow.

Reset
REQ-033 rst low SHALL asynchronously force IDLE, clear all counters and cfg registers, and drive in_ready, buf_mode, buf_w_en, buf_r_en, rd_valid, rd_last, busy, done and err to 0, with buf_w_addr = buf_r_addr = 0.
REQ-034 Reset assertion mid-LOAD or mid-STREAM SHALL abandon the job; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-035 cfg_words=4, cfg_nbuf=2, in_valid held 1 -> 8 writes: buf_w_en=0x01 at addr 0..3, then 0x02 at addr 0..3; STREAM reads addr 0..3 with buf_r_en=0x03; done is 14 cycles after start.
REQ-036 Same job with in_valid toggling 1,0 -> writes only on in_valid cycles; order and addresses are unchanged.
REQ-037 pe_stall=1 for 3 cycles mid-STREAM -> no buf_r_en in those cycles; addresses stay contiguous; rd_valid gap = 3 cycles.
REQ-038 start with cfg_nbuf=9 (N_BUF=8) -> err pulse, busy stays 0; start with cfg_words=0 -> same.
REQ-039 abort after 3 accepted words -> IDLE next cycle, no done; a subsequent start runs a full job from buffer 0, addr 0.
REQ-040 rst low during STREAM -> all outputs 0 immediately, without waiting for a clock edge; cfg_words=1024, cfg_nbuf=8 job then completes with rd_last at addr 1023.

Source files
------------

// File: rtl/buffer_sequencer_if.sv
// Buffer sequencer bus interface.
// Groups the serial load stream, the consumer stall, the buffer write/read
// ports and the read-data status flags that travel between the sequencer
// and its environment.
//   master : the sequencer (accepts the load stream, drives the buffers)
//   slave  : the environment (supplies the load stream, owns the buffers)
interface buffer_sequencer_if #(
  parameter int N_BUF       = 8,
  parameter int ADDR_RAM    = 10,
  parameter int WID_PE_BITS = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WID_PE_BITS-1:0] in_data;
  logic                   pe_stall;
  logic                   buf_mode;
  logic [N_BUF-1:0]       buf_w_en;
  logic [ADDR_RAM-1:0]    buf_w_addr;
  logic [WID_PE_BITS-1:0] buf_w_data;
  logic [N_BUF-1:0]       buf_r_en;
  logic [ADDR_RAM-1:0]    buf_r_addr;
  logic                   rd_valid;
  logic                   rd_last;

  modport master (
    input  in_valid, in_data, pe_stall,
    output in_ready, buf_mode, buf_w_en, buf_w_addr, buf_w_data,
           buf_r_en, buf_r_addr, rd_valid, rd_last
  );

  modport slave (
    output in_valid, in_data, pe_stall,
    input  in_ready, buf_mode, buf_w_en, buf_w_addr, buf_w_data,
           buf_r_en, buf_r_addr, rd_valid, rd_last
  );
endinterface

// File: rtl/buffer_sequencer.sv
// Buffer sequencer.
// Runs one load+stream job per start: a serial word stream is written into
// cfg_nbuf buffers in buffer-major order (cfg_words words each), then all
// used buffers are read in parallel, one shared address per cycle, while the
// consumer is not stalling.
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-low reset
//   start      : one-cycle job request (honoured only in IDLE)
//   abort      : synchronous job cancel, wins over start
//   cfg_words  : words per buffer, 1..2^ADDR_RAM
//   cfg_nbuf   : buffers used, 1..N_BUF
//   bus        : load stream, buffer write/read ports, read-data flags
//   busy       : job in progress (LOAD, STREAM, DONE)
//   done / err : one-cycle completion / rejected-configuration pulses
module buffer_sequencer #(
  parameter int N_BUF       = 8,
  parameter int ADDR_RAM    = 10,
  parameter int WID_PE_BITS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ADDR_RAM:0]         cfg_words,
  input  logic [$clog2(N_BUF):0]    cfg_nbuf,
  buffer_sequencer_if.master        bus,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int NB_W  = $clog2(N_BUF) + 1;
  // One spare bit so a full 2^ADDR_RAM word count is representable.
  localparam int CNT_W = ADDR_RAM + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] words_q;
  logic [NB_W-1:0]  nbuf_q;
  logic [CNT_W-1:0] word_cnt;
  logic [NB_W-1:0]  buf_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic             rd_vld_p1;
  logic             rd_last_p1;
  logic             err_p1;

  logic             cfg_ok;
  logic [CNT_W-1:0] last_word;
  logic [NB_W-1:0]  last_buf;
  logic             word_end;
  logic             buf_end;
  logic             rd_end;
  logic             accept;
  logic             issue;
  logic [N_BUF-1:0] w_en;
  logic [N_BUF-1:0] rd_mask;

  assign cfg_ok = (cfg_words != '0) && (cfg_words <= CNT_W'(1 << ADDR_RAM)) &&
                  (cfg_nbuf != '0) && (cfg_nbuf <= NB_W'(N_BUF));

  assign last_word = words_q - CNT_W'(1);
  assign last_buf  = nbuf_q - NB_W'(1);
  assign word_end  = (word_cnt == last_word);
  assign buf_end   = (buf_cnt == last_buf);
  assign rd_end    = (rd_cnt == last_word);

  // abort closes both the load handshake and read issue in its own cycle.
  assign bus.in_ready = (state == S_LOAD) && !abort;
  assign accept       = bus.in_valid && bus.in_ready;
  assign issue        = (state == S_STREAM) && !bus.pe_stall && !abort;

  always_comb begin
    w_en    = '0;
    rd_mask = '0;
    for (int i = 0; i < N_BUF; i++) begin
      w_en[i]    = accept && (buf_cnt == NB_W'(i));
      rd_mask[i] = (NB_W'(i) < nbuf_q);
    end
  end

  assign bus.buf_w_en   = w_en;
  assign bus.buf_w_addr = word_cnt[ADDR_RAM-1:0];
  assign bus.buf_w_data = bus.in_data;
  assign bus.buf_r_en   = issue ? rd_mask : '0;
  assign bus.buf_r_addr = rd_cnt[ADDR_RAM-1:0];
  assign bus.buf_mode   = (state == S_STREAM);

  // Read-data flags are registered; abort masks any flag still in flight.
  assign bus.rd_valid = rd_vld_p1 && !abort;
  assign bus.rd_last  = rd_last_p1 && !abort;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE) && !abort;
  assign err  = err_p1;

  // p0 -> p1: control state and read-data flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      words_q    <= '0;
      nbuf_q     <= '0;
      word_cnt   <= '0;
      buf_cnt    <= '0;
      rd_cnt     <= '0;
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
      err_p1     <= 1'b0;
    end else begin
      rd_vld_p1  <= issue;
      rd_last_p1 <= issue && rd_end;
      err_p1     <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        word_cnt <= '0;
        buf_cnt  <= '0;
        rd_cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                words_q  <= cfg_words;
                nbuf_q   <= cfg_nbuf;
                word_cnt <= '0;
                buf_cnt  <= '0;
                rd_cnt   <= '0;
                state    <= S_LOAD;
              end else begin
                err_p1 <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            if (accept) begin
              if (word_end) begin
                word_cnt <= '0;
                if (buf_end) state <= S_STREAM;
                else         buf_cnt <= buf_cnt + NB_W'(1);
              end else begin
                word_cnt <= word_cnt + CNT_W'(1);
              end
            end
          end
          S_STREAM: begin
            if (!bus.pe_stall) begin
              rd_cnt <= rd_cnt + CNT_W'(1);
              if (rd_end) state <= S_DONE;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buffer_sequencer.sv
module tb_buffer_sequencer;
  localparam int N_BUF = 8;
  localparam int ADDR_RAM = 10;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [ADDR_RAM:0] cfg_words = '0;
  logic [3:0] cfg_nbuf = '0;
  logic busy, done, err;

  buffer_sequencer_if #(.N_BUF(N_BUF), .ADDR_RAM(ADDR_RAM), .WID_PE_BITS(W)) bus ();

  buffer_sequencer #(.N_BUF(N_BUF), .ADDR_RAM(ADDR_RAM), .WID_PE_BITS(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_words(cfg_words), .cfg_nbuf(cfg_nbuf), .bus(bus),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  // Expected-response queues filled by stimulus, drained by the monitor.
  logic [33:0] wq[$];    // {buf_w_en, buf_w_addr, buf_w_data}
  logic [17:0] rq[$];    // {buf_r_en, buf_r_addr}
  int          rq_c[$];  // cycle of each read issue
  bit          vq_l[$];  // rd_last expected with each rd_valid
  int          vq_c[$];  // cycle of each rd_valid
  int          dq[$];    // cycle of done
  int          eq[$];    // cycle of err

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [42:0] all_outs();
    return {bus.in_ready, bus.buf_mode, bus.buf_w_en, bus.buf_w_addr, bus.buf_r_en,
            bus.buf_r_addr, bus.rd_valid, bus.rd_last, busy, done, err};
  endfunction

  task automatic flush();
    wq.delete(); rq.delete(); rq_c.delete(); vq_l.delete(); vq_c.delete();
    dq.delete(); eq.delete();
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_writes_left"}, 64'(wq.size()), 64'd0);
    check({tag, "_reads_left"}, 64'(rq.size()), 64'd0);
    check({tag, "_rdvalid_left"}, 64'(vq_c.size()), 64'd0);
    check({tag, "_done_left"}, 64'(dq.size()), 64'd0);
    check({tag, "_err_left"}, 64'(eq.size()), 64'd0);
  endtask

  // Monitor: compare every presented output against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (|bus.buf_w_en) begin
        if (wq.size() == 0) check("write_unexpected", 64'(bus.buf_w_en), 64'd0);
        else begin
          check("write", 64'({bus.buf_w_en, bus.buf_w_addr, bus.buf_w_data}), 64'(wq.pop_front()));
          check("mode_load", 64'(bus.buf_mode), 64'd0);
        end
      end
      if (|bus.buf_r_en) begin
        if (rq.size() == 0) check("read_unexpected", 64'(bus.buf_r_en), 64'd0);
        else begin
          check("read", 64'({bus.buf_r_en, bus.buf_r_addr}), 64'(rq.pop_front()));
          check("read_cycle", 64'(cyc), 64'(rq_c.pop_front()));
          check("mode_stream", 64'(bus.buf_mode), 64'd1);
        end
      end
      if (bus.rd_valid) begin
        if (vq_c.size() == 0) check("rd_valid_unexpected", 64'(bus.rd_valid), 64'd0);
        else begin
          check("rd_last", 64'(bus.rd_last), 64'(vq_l.pop_front()));
          check("rd_valid_cycle", 64'(cyc), 64'(vq_c.pop_front()));
        end
      end else if (bus.rd_last) begin
        check("rd_last_without_valid", 64'(bus.rd_last), 64'd0);
      end
      if (done) begin
        if (dq.size() == 0) check("done_unexpected", 64'(done), 64'd0);
        else check("done_cycle", 64'(cyc), 64'(dq.pop_front()));
      end
      if (err) begin
        if (eq.size() == 0) check("err_unexpected", 64'(err), 64'd0);
        else check("err_cycle", 64'(cyc), 64'(eq.pop_front()));
      end
    end
  end

  // One full job. Cycle c is the cycle whose rising edge has just passed.
  // The start cycle is s; LOAD begins at s+1; the read of the last address
  // sits one cycle before DONE. For 4 words x 2 buffers with in_valid held
  // high, DONE falls in cycle s+13 (14 cycles counting start and done).
  task automatic run_job(input int words, input int nbuf, input bit toggle,
                         input int stall_at, input int stall_len,
                         input bit poke, input int rst_at);
    int s, k, c, rc, total;
    bit iv;
    logic [7:0] mask;
    logic [7:0] oh;
    logic [15:0] d;
    total = words * nbuf;
    mask = 8'((1 << nbuf) - 1);
    s = cyc;
    start = 1'b1;
    cfg_words = 11'(words);
    cfg_nbuf = 4'(nbuf);
    tick();
    start = 1'b0;
    k = 0;
    c = s + 1;
    while (k < total) begin
      if (poke && c == s + 1) begin
        // a start with a different cfg during LOAD must change nothing
        start = 1'b1;
        cfg_words = 11'd1;
        cfg_nbuf = 4'd1;
      end else begin
        start = 1'b0;
      end
      iv = !toggle || (((c - s - 1) % 2) == 0);
      bus.in_valid = iv;
      if (iv) begin
        d = 16'(k * 37 + 16'h1234);
        bus.in_data = d;
        oh = 8'(1) << (k / words);
        wq.push_back({oh, 10'(k % words), d});
        k++;
      end
      tick();
      c++;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    rc = c;
    for (int j = 0; j < words; j++) begin
      if (j == rst_at) begin
        rst = 1'b0;
        #1;
        check("async_reset_outputs", 64'(all_outs()), 64'd0);
        flush();
        return;
      end
      if (j == stall_at) begin
        repeat (stall_len) begin
          bus.pe_stall = 1'b1;
          tick();
          rc++;
        end
      end
      bus.pe_stall = 1'b0;
      rq.push_back({mask, 10'(j)});
      rq_c.push_back(rc);
      vq_l.push_back(j == words - 1);
      vq_c.push_back(rc + 1);
      if (j == words - 1) dq.push_back(rc + 1);
      tick();
      rc++;
    end
    tick();
    tick();
    check("busy_after_job", 64'(busy), 64'd0);
    check_drained("job");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.pe_stall = 1'b0;

    // reset state
    #12;
    check("reset_outputs", 64'(all_outs()), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_in_ready", 64'(bus.in_ready), 64'd0);

    // basic job, in_valid held high
    run_job(4, 2, 1'b0, -1, 0, 1'b0, -1);
    // same job with in_valid toggling; a start during LOAD is ignored
    run_job(4, 2, 1'b1, -1, 0, 1'b1, -1);
    // stall of 3 cycles mid-stream, three buffers
    run_job(8, 3, 1'b0, 3, 3, 1'b0, -1);
    // single word, single buffer
    run_job(1, 1, 1'b0, -1, 0, 1'b0, -1);

    // invalid configurations: err pulse, busy stays low
    begin
      int s;
      s = cyc; start = 1'b1; cfg_words = 11'd4; cfg_nbuf = 4'd9;
      eq.push_back(s + 1);
      tick(); start = 1'b0;
      check("err_nbuf9_busy", 64'(busy), 64'd0);
      tick();
      check("err_nbuf9_busy2", 64'(busy), 64'd0);
      s = cyc; start = 1'b1; cfg_words = 11'd0; cfg_nbuf = 4'd2;
      eq.push_back(s + 1);
      tick(); start = 1'b0;
      check("err_words0_busy", 64'(busy), 64'd0);
      tick();
      check("err_words0_busy2", 64'(busy), 64'd0);
      s = cyc; start = 1'b1; cfg_words = 11'd4; cfg_nbuf = 4'd0;
      eq.push_back(s + 1);
      tick(); start = 1'b0;
      tick();
      check("err_nbuf0_busy", 64'(busy), 64'd0);
      check_drained("err");
    end

    // abort and start together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; cfg_words = 11'd4; cfg_nbuf = 4'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 64'(busy), 64'd0);
    tick();
    check("abort_start_busy2", 64'(busy), 64'd0);

    // abort after 3 accepted words
    start = 1'b1; cfg_words = 11'd4; cfg_nbuf = 4'd2;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [15:0] d;
      d = 16'hBEE0 + 16'(k);
      bus.in_valid = 1'b1;
      bus.in_data = d;
      wq.push_back({8'h01, 10'(k), d});
      tick();
    end
    abort = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    check("abort_in_ready", 64'(bus.in_ready), 64'd0);
    check("abort_w_en", 64'(bus.buf_w_en), 64'd0);
    tick();
    abort = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_idle_busy", 64'(busy), 64'd0);
    tick();
    check_drained("abort");
    run_job(4, 2, 1'b0, -1, 0, 1'b0, -1);

    // asynchronous reset mid-stream, then a full-size job
    run_job(4, 2, 1'b0, -1, 0, 1'b0, 2);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("post_reset_idle", 64'(busy), 64'd0);
    run_job(1024, 8, 1'b0, -1, 0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
